// File: rtl/dus_host.sv
// Host-side controller for an ap_ctrl_hs kernel: launches batches of runs, guards each run
// with a watchdog, and serves the kernel's img (read-only) and dus memories plus a host read port.
module dus_host #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [7:0]        num_runs,
  output logic              busy,
  output logic              batch_done,
  output logic              timeout_err,
  output logic [7:0]        run_count,
  output logic [DATA_W-1:0] checksum,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              ap_start,
  input  logic              ap_done,
  input  logic              ap_ready,
  input  logic              ap_idle,
  input  logic              img_ce0,
  input  logic              img_we0,
  input  logic [ADDR_W-1:0] img_address0,
  input  logic [DATA_W-1:0] img_d0,
  output logic [DATA_W-1:0] img_q0,
  input  logic              dus_ce0,
  input  logic              dus_we0,
  input  logic [ADDR_W-1:0] dus_address0,
  input  logic [DATA_W-1:0] dus_d0,
  output logic [DATA_W-1:0] dus_q0
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_FINISH} state_t;

  state_t            state, state_nxt;
  logic [WD_W-1:0]   wdog;
  logic [7:0]        target;
  logic              accept, run_done, tmo, last_run, wd_expired;

  logic [DATA_W-1:0] img_mem [DEPTH];
  logic [DATA_W-1:0] dus_mem [DEPTH];

  // Kernel has read-only img access and the idle status is informational only.
  logic unused_ok;
  assign unused_ok = ^{img_we0, img_d0, ap_idle};

  assign wd_expired = (wdog == WD_W'(TIMEOUT));
  assign last_run   = ((9'(run_count) + 9'd1) == 9'(target));

  // Next-state logic; a done coincident with watchdog expiry wins over the timeout.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    run_done  = 1'b0;
    tmo       = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          accept    = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (ap_ready && ap_done) begin
          run_done  = 1'b1;
          state_nxt = S_FINISH;
        end else if (wd_expired) begin
          tmo       = 1'b1;
          state_nxt = S_FINISH;
        end else if (ap_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ap_done) begin
          run_done  = 1'b1;
          state_nxt = last_run ? S_FINISH : S_START;
        end else if (wd_expired) begin
          tmo       = 1'b1;
          state_nxt = S_FINISH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, status and watchdog registers; handshake outputs follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wdog        <= '0;
      target      <= 8'd1;
      ap_start    <= 1'b0;
      busy        <= 1'b0;
      batch_done  <= 1'b0;
      timeout_err <= 1'b0;
      run_count   <= '0;
      checksum    <= '0;
    end else begin
      state      <= state_nxt;
      ap_start   <= (state_nxt == S_START);
      busy       <= (state_nxt != S_IDLE);
      batch_done <= (state_nxt == S_FINISH);

      if (state_nxt == S_START && state != S_START) begin
        wdog <= '0;
      end else if (state == S_START || state == S_WAIT) begin
        wdog <= wdog + WD_W'(1);
      end

      if (accept) begin
        target      <= (num_runs == 8'd0) ? 8'd1 : num_runs;
        run_count   <= '0;
        timeout_err <= 1'b0;
      end else begin
        if (run_done && run_count != 8'hFF) run_count <= run_count + 8'd1;
        if (tmo) timeout_err <= 1'b1;
      end

      if (accept) begin
        checksum <= '0;
      end else if (state != S_IDLE && dus_ce0 && dus_we0) begin
        checksum <= checksum + dus_d0;
      end
    end
  end

  // Memory arrays keep their contents across reset.
  always_ff @(posedge clk) begin
    if (load_we && state == S_IDLE) img_mem[load_addr] <= load_data;
    if (dus_ce0 && dus_we0) dus_mem[dus_address0] <= dus_d0;
  end

  // Read ports; rd_data sees pre-write contents on a same-cycle kernel write.
  always_ff @(posedge clk) begin
    if (rst) begin
      img_q0  <= '0;
      dus_q0  <= '0;
      rd_data <= '0;
    end else begin
      if (img_ce0) img_q0 <= img_mem[img_address0];
      if (dus_ce0 && !dus_we0) dus_q0 <= dus_mem[dus_address0];
      rd_data <= dus_mem[rd_addr];
    end
  end

endmodule
